// File: rtl/store_byte_serializer.sv
// store_byte_serializer: emits a 32-bit store as sequential byte writes; STORE_BIG_ENDIAN_EN selects MSB-first order within the sized field
module store_byte_serializer #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              ST_REQ,
  input  logic [ADDR_W-1:0] ST_ADDR,
  input  logic [31:0]       ST_DATA,
  input  logic [1:0]        ST_SIZE,
  output logic              ST_ACK,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_DO,
  output logic              MEM_WE,
  input  logic              MEM_RDY
);
  typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;
  state_t state;
  logic [31:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] cnt_q, idx_q, nidx, req_cnt;
  function automatic logic [7:0] pick(input logic [31:0] d, input logic [1:0] i, input logic [1:0] c);
    logic [1:0] j;
`ifdef STORE_BIG_ENDIAN_EN
    j = c - i;
`else
    j = i;
    j = j | (c & 2'b00);
`endif
    return d[{j, 3'b000} +: 8];
  endfunction
  always_comb begin
    nidx = idx_q + 2'd1;
    req_cnt = ST_SIZE == 2'b00 ? 2'd0 : ST_SIZE == 2'b01 ? 2'd1 : 2'd3;
  end
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= IDLE;
      ST_ACK <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      MEM_WE <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DO <= '0;
      data_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      ST_ACK <= 1'b0;
      case (state)
        IDLE: if (ST_REQ) begin
          state <= WRITE;
          data_q <= ST_DATA;
          addr_q <= ST_ADDR;
          cnt_q <= req_cnt;
          idx_q <= 2'd0;
          ST_ACK <= 1'b1;
          BUSY <= 1'b1;
          MEM_WE <= 1'b1;
          MEM_ADDR <= ST_ADDR;
          MEM_DO <= pick(ST_DATA, 2'd0, req_cnt);
        end
        WRITE: if (MEM_RDY) begin
          if (idx_q == cnt_q) begin
            state <= FIN;
            MEM_WE <= 1'b0;
            DONE <= 1'b1;
          end else begin
            idx_q <= nidx;
            MEM_ADDR <= addr_q + ADDR_W'(nidx);
            MEM_DO <= pick(data_q, nidx, cnt_q);
          end
        end
        FIN: begin
          state <= IDLE;
          DONE <= 1'b0;
          BUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/store_byte_serializer.md
Name: store_byte_serializer

Overview:
- Store-side counterpart of the byte-wide instruction fetch path in miniMIPS.
- Fetch assembles a 32-bit word from four sequential byte loads. This block does the reverse for stores: it takes a 32-bit store word, address and size, and emits it as sequential byte writes on the 8-bit memory bus.
- Sits between the execute-stage store request and data memory; one store in flight at a time.

Parameters:
- ADDR_W, 8, width of byte address on both store request and memory side.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- CLR  input  1  synchronous reset, active high.
- ST_REQ  input  1  store request; sampled only in IDLE.
- ST_ADDR  input  ADDR_W  byte address of first byte.
- ST_DATA  input  32  store data; sized field is right-justified (byte in [7:0], half in [15:0]).
- ST_SIZE  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- ST_ACK  output  1  one-cycle pulse: request captured.
- BUSY  output  1  high while a store is in progress, including the DONE cycle.
- DONE  output  1  one-cycle pulse after the last byte is accepted.
- MEM_ADDR  output  ADDR_W  byte write address.
- MEM_DO  output  8  byte write data.
- MEM_WE  output  1  write strobe.
- MEM_RDY  input  1  memory accepts the current byte this cycle.

Behaviour:
- Reset (CLR=1 at an edge): state IDLE; ST_ACK, BUSY, DONE, MEM_WE = 0; MEM_ADDR, MEM_DO = 0; internal data, address and count registers = 0. Reset overrides everything, including mid-store. MEM_WE is low in the cycle after the reset edge. A partial store is abandoned; bytes already written are not undone.
- States: IDLE, WRITE, FIN. All outputs are registered.
- IDLE, ST_REQ=1 at edge k:
  - Capture ST_DATA, ST_ADDR and count N-1, where N = 1, 2 or 4 from ST_SIZE (11 gives N=4).
  - Byte index idx = 0.
  - Next state WRITE.
  - During cycle k+1: ST_ACK=1 for that cycle only, BUSY=1, MEM_WE=1.
- WRITE:
  - MEM_WE=1.
  - MEM_ADDR = captured address + idx, modulo 2^ADDR_W. Wrap from all-ones to 0 is legal.
  - MEM_DO = byte idx of captured data; little-endian, byte 0 = data[7:0].
  - MEM_RDY=1 at an edge completes the byte: if idx = N-1, go to FIN; otherwise idx+1.
  - MEM_RDY=0: hold MEM_ADDR, MEM_DO and MEM_WE unchanged. Stalls are unbounded.
- FIN: MEM_WE=0, DONE=1, BUSY=1 for exactly one cycle, then IDLE.
- ST_REQ in WRITE or FIN is ignored (no ACK, no capture). The requester holds ST_REQ until ST_ACK.
- ST_REQ held high continuously: one new store is accepted per return to IDLE.
- No alignment check; misaligned half/word stores write sequential bytes.
- Latency with MEM_RDY tied high:
  - Word: request edge k; bytes in cycles k+1..k+4; DONE in k+5; next request sampled at edge ending k+6.
  - Byte store: DONE in k+2.
- Upper ST_DATA bits beyond the sized field are ignored.

Optional Feature:
- Macro STORE_BIG_ENDIAN_EN.
- Defined: byte order is reversed within the sized field. idx 0 drives the most significant byte of the field: word data[31:24], half data[15:8], byte data[7:0]. Address still increments from ST_ADDR.
- Undefined: little-endian as specified in Behaviour.
- Timing, handshake and addressing are identical in both builds.

Test Plan:
- Reset, then word store, ADDR=8'h10, DATA=32'hA1B2C3D4, RDY=1: ACK pulse at k+1; writes (10,D4),(11,C3),(12,B2),(13,A1) in cycles k+1..k+4; DONE at k+5; MEM_WE=0 at k+5.
- Half store, ADDR=8'hFF, DATA=32'hXXXX5A6B, RDY=1: writes (FF,6B),(00,5A); DONE two cycles after ACK cycle; address wrap verified.
- Byte store, DATA=32'h000000E7, RDY low for 3 cycles then high: MEM_WE/ADDR/DO held stable for 4 cycles, single write of E7, DONE next cycle.
- Second ST_REQ asserted during WRITE of a word store: no second ACK until after DONE; second store starts only after IDLE is re-entered.
- CLR=1 after byte 1 of a word store: MEM_WE=0, BUSY=0, DONE=0 next cycle; no further writes; new request afterwards behaves per the first scenario.
- With STORE_BIG_ENDIAN_EN, the first scenario writes (10,A1),(11,B2),(12,C3),(13,D4).
